id_queue_stage: RTL
===================

Name: id_queue_stage

Overview:
- Buffered, pipelined successor to the single-cycle combinational control decoder.
- Accepts fetched {pc, inst} pairs into a DEPTH-entry queue and decodes the queue head for the RV64I base set plus the W-ops.
- Drives a registered decoded-control bundle to execute under a valid/ready handshake.
- Adds flush, halt-on-trap sequencing and stall/back-pressure that the single-cycle decoder lacks.

Parameters:
- XLEN, 64, datapath and pc width; immediates sign-extended to XLEN.
- DEPTH, 4, queue entries; power of two, >=2.
- PTR_W, $clog2(DEPTH), queue pointer width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  fetch presents pc/inst.
- in_ready  out  1  queue not full and state RUN.
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- flush  in  1  discard queue and output register.
- dec_valid  out  1  decoded bundle valid.
- dec_ready  in  1  execute accepts bundle.
- dec_pc  out  XLEN  pc of bundle.
- dec_rs1 / dec_rs2 / dec_rd  out  5 each  register addresses; 0 when unused.
- dec_reg_wen  out  1  rd write; forced 0 when rd==0.
- dec_imm  out  XLEN  sign-extended I/S/B/U/J immediate.
- dec_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- dec_alu_src  out  2  0 reg/reg, 1 reg/imm, 2 pc/imm, 3 pc/4.
- dec_word  out  1  32-bit op; result sign-extended from bit 31.
- dec_branch  out  1  conditional branch; condition = dec_funct3.
- dec_jump  out  1  JAL or JALR.
- dec_jalr  out  1  JALR.
- dec_mem_rd  out  1  load.
- dec_mem_wr  out  1  store.
- dec_funct3  out  3  raw funct3 (size/unsigned/branch condition).
- dec_illegal  out  1  unsupported encoding.
- dec_ebreak  out  1  inst == 0x00100073.
- halted  out  1  state HALT.

Behaviour:
- Reset: queue empty, pointers 0, state RUN, dec_valid 0, all dec_* 0, halted 0.
- Push when in_valid && in_ready. Pop when head exists, state RUN, and output register empty or dec_ready high.
- Output register loads decoded head on pop. dec_valid clears on dec_ready with no pop.
- Latency: pushed at edge N, dec_valid high after edge N+1. Sustained throughput is 1/cycle.
- Full queue: in_ready 0. Push and pop in the same cycle on a full queue is legal; count is unchanged.
- Empty queue with dec_ready high: dec_valid drops 0.
- Pointers wrap modulo DEPTH. Full/empty use a PTR_W+1 bit count.
- Illegal: any opcode outside LUI, AUIPC, JAL, JALR (funct3 0), BRANCH (funct3 != 2,3), LOAD (funct3 != 7), STORE (funct3 0-3), OP-IMM, OP, OP-IMM-32, OP-32, SYSTEM==EBREAK. Also illegal: funct7 not in {0x00, 0x20}, or 0x20 on a non-SUB/SRA op. RV64 shift immediates use funct6.
- On illegal: dec_illegal 1, reg_wen/mem_wr/branch/jump forced 0.
- State machine:
  - RUN -> HALT when a bundle with dec_illegal or dec_ebreak is loaded into the output register.
  - HALT: no pop; in_ready 0; the trap bundle stays presented until dec_ready, then dec_valid 0.
  - HALT -> RUN only on flush.
- flush (any state): next edge empties queue, clears dec_valid, state RUN. Any push or pop in the flush cycle is discarded. flush has priority over everything.
- Reset asserted mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined: adds outputs perf_issued (64) and perf_stall (64). perf_issued increments on each dec_valid && dec_ready. perf_stall increments each cycle dec_valid && !dec_ready. Both are cleared only by rst and wrap at 2^64.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Push addi x1,x0,5 (0x00500093) at pc 0x80000000, dec_ready=1 -> after 2 edges: dec_valid=1, rd=1, rs1=0, imm=5, alu_op=0, alu_src=1, reg_wen=1.
- Hold dec_ready=0, push 5 instructions with DEPTH=4 -> in_ready=0 after 4 queued plus 1 in the output register. Then release -> 5 bundles in order on consecutive cycles.
- Push sd x2,-8(x3) (0xFE21BC23) -> mem_wr=1, funct3=3, rs1=3, rs2=2, reg_wen=0, imm=0xFFFFFFFFFFFFFFF8.
- Push 0x00100073 then addi -> dec_ebreak=1, halted=1, in_ready=0, addi not issued. After flush: halted=0, queue empty, dec_valid=0.
- Push 0xFFFFFFFF -> dec_illegal=1, reg_wen=0, halted=1.
- Push addw x5,x6,x7 (0x007302BB) and beq x1,x2,-4 (0xFE208EE3) -> dec_word=1, alu_op=0. beq: branch=1, funct3=0, imm=-4.

Source files
------------

// File: rtl/id_queue_stage.sv
// id_queue_stage: DEPTH-entry fetch queue feeding a registered RV64I(+W) decoder with a valid/ready output.
// Define ID_PERF_CNT_EN to add the perf_issued/perf_stall handshake counters.
module id_queue_stage #(
   parameter  int XLEN  = 64,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   input  logic            flush,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [4:0]      dec_rs1,
   output logic [4:0]      dec_rs2,
   output logic [4:0]      dec_rd,
   output logic            dec_reg_wen,
   output logic [XLEN-1:0] dec_imm,
   output logic [3:0]      dec_alu_op,
   output logic [1:0]      dec_alu_src,
   output logic            dec_word,
   output logic            dec_branch,
   output logic            dec_jump,
   output logic            dec_jalr,
   output logic            dec_mem_rd,
   output logic            dec_mem_wr,
   output logic [2:0]      dec_funct3,
   output logic            dec_illegal,
   output logic            dec_ebreak,
   output logic            halted
`ifdef ID_PERF_CNT_EN
   ,
   output logic [63:0]     perf_issued,
   output logic [63:0]     perf_stall
`endif
);

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [1:0] SRC_RR = 2'd0;
   localparam logic [1:0] SRC_RI = 2'd1;
   localparam logic [1:0] SRC_PI = 2'd2;
   localparam logic [1:0] SRC_P4 = 2'd3;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [4:0]             rs1;
      logic [4:0]             rs2;
      logic [4:0]             rd;
      logic                   reg_wen;
      logic signed [XLEN-1:0] imm;
      logic [3:0]             alu_op;
      logic [1:0]             alu_src;
      logic                   word;
      logic                   branch;
      logic                   jump;
      logic                   jalr;
      logic                   mem_rd;
      logic                   mem_wr;
      logic [2:0]             funct3;
      logic                   illegal;
      logic                   ebreak;
   } bundle_t;

   typedef enum logic {S_RUN, S_HALT} state_t;

   function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] inst);
      return {{(XLEN-12){inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] inst);
      return {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
   endfunction

   function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] inst);
      return {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] inst);
      return {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
   endfunction

   function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] inst);
      return {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   // funct3 -> ALU op; alt selects SUB/SRA for the encodings that have an alternate form
   function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic f7_bad(input logic [6:0] f7, input logic [2:0] f3);
      return !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
   endfunction

   function automatic bundle_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
      bundle_t    b;
      logic [6:0] f7;
      logic [5:0] f6;
      logic [2:0] f3;
      logic       bad;
      b      = '0;
      bad    = 1'b0;
      f7     = inst[31:25];
      f6     = inst[31:26];
      f3     = inst[14:12];
      b.pc     = pc;
      b.funct3 = f3;
      case (inst[6:0])
         OPC_LUI: begin
            b.rd = inst[11:7]; b.reg_wen = 1'b1; b.imm = imm_u(inst); b.alu_src = SRC_RI;
         end
         OPC_AUIPC: begin
            b.rd = inst[11:7]; b.reg_wen = 1'b1; b.imm = imm_u(inst); b.alu_src = SRC_PI;
         end
         OPC_JAL: begin
            b.rd = inst[11:7]; b.reg_wen = 1'b1; b.imm = imm_j(inst); b.alu_src = SRC_P4;
            b.jump = 1'b1;
         end
         OPC_JALR: begin
            b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.reg_wen = 1'b1; b.imm = imm_i(inst);
            b.alu_src = SRC_P4; b.jump = 1'b1; b.jalr = 1'b1;
            bad = (f3 != 3'd0);
         end
         OPC_BRANCH: begin
            b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.imm = imm_b(inst); b.branch = 1'b1;
            b.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            bad = (f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.reg_wen = 1'b1; b.imm = imm_i(inst);
            b.alu_src = SRC_RI; b.mem_rd = 1'b1;
            bad = (f3 == 3'd7);
         end
         OPC_STORE: begin
            b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.imm = imm_s(inst);
            b.alu_src = SRC_RI; b.mem_wr = 1'b1;
            bad = f3[2];
         end
         OPC_OPIMM: begin
            // 64-bit shift amounts are 6 bits wide, so only funct6 qualifies the shift
            b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.reg_wen = 1'b1; b.imm = imm_i(inst);
            b.alu_src = SRC_RI;
            b.alu_op = alu_f3(f3, (f3 == 3'd5) && (f6 == 6'h10));
            bad = ((f3 == 3'd1) && (f6 != 6'h00)) ||
                  ((f3 == 3'd5) && (f6 != 6'h00) && (f6 != 6'h10));
         end
         OPC_OP: begin
            b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.reg_wen = 1'b1;
            b.alu_src = SRC_RR; b.alu_op = alu_f3(f3, f7[5]);
            bad = f7_bad(f7, f3);
         end
         OPC_OPIMM32: begin
            b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.reg_wen = 1'b1; b.imm = imm_i(inst);
            b.alu_src = SRC_RI; b.word = 1'b1;
            b.alu_op = alu_f3(f3, (f3 == 3'd5) && f7[5]);
            bad = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5)) ||
                  ((f3 != 3'd0) && f7_bad(f7, f3));
         end
         OPC_OP32: begin
            b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.reg_wen = 1'b1;
            b.alu_src = SRC_RR; b.word = 1'b1; b.alu_op = alu_f3(f3, f7[5]);
            bad = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5)) || f7_bad(f7, f3);
         end
         OPC_SYSTEM: begin
            if (inst == INST_EBREAK) b.ebreak = 1'b1;
            else                     bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (b.rd == 5'd0) b.reg_wen = 1'b0;
      if (bad) begin
         b.illegal = 1'b1;
         b.reg_wen = 1'b0;
         b.mem_wr  = 1'b0;
         b.branch  = 1'b0;
         b.jump    = 1'b0;
      end
      return b;
   endfunction

   logic [XLEN-1:0]  q_pc   [DEPTH];
   logic [31:0]      q_inst [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty, push, pop;
   state_t           state, state_nxt;
   bundle_t          head_p0, bnd_p1;
   logic             vld_p1;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign push  = in_valid && in_ready;

   // ---- stage p0: queue head decoded combinationally ----
   always_comb head_p0 = decode(q_inst[rd_ptr], q_pc[rd_ptr]);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      pop       = 1'b0;
      case (state)
         S_RUN: begin
            in_ready = !full;
            pop      = !empty && (!vld_p1 || dec_ready);
            if (pop && (head_p0.illegal || head_p0.ebreak)) state_nxt = S_HALT;
         end
         S_HALT: begin
         end
         default: state_nxt = S_RUN;
      endcase
      if (flush) state_nxt = S_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         q_pc[wr_ptr]   <= in_pc;
         q_inst[wr_ptr] <= in_inst;
      end
   end

   // ---- stage p1: registered bundle presented to execute ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         bnd_p1 <= '0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (pop) begin
         vld_p1 <= 1'b1;
         bnd_p1 <= head_p0;
      end else if (dec_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign dec_valid   = vld_p1;
   assign dec_pc      = bnd_p1.pc;
   assign dec_rs1     = bnd_p1.rs1;
   assign dec_rs2     = bnd_p1.rs2;
   assign dec_rd      = bnd_p1.rd;
   assign dec_reg_wen = bnd_p1.reg_wen;
   assign dec_imm     = bnd_p1.imm;
   assign dec_alu_op  = bnd_p1.alu_op;
   assign dec_alu_src = bnd_p1.alu_src;
   assign dec_word    = bnd_p1.word;
   assign dec_branch  = bnd_p1.branch;
   assign dec_jump    = bnd_p1.jump;
   assign dec_jalr    = bnd_p1.jalr;
   assign dec_mem_rd  = bnd_p1.mem_rd;
   assign dec_mem_wr  = bnd_p1.mem_wr;
   assign dec_funct3  = bnd_p1.funct3;
   assign dec_illegal = bnd_p1.illegal;
   assign dec_ebreak  = bnd_p1.ebreak;
   assign halted      = (state == S_HALT);

`ifdef ID_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (vld_p1 && dec_ready)  perf_issued <= perf_issued + 64'd1;
         if (vld_p1 && !dec_ready) perf_stall  <= perf_stall + 64'd1;
      end
   end
`endif

endmodule
